// File: rtl/grid_backtrack_engine_if.sv
// -----------------------------------------------------------------------------
// grid_backtrack_engine_if
// Purpose : groups the load, start, read-back and status signals between the
//           top-level controller (master) and the backtracking engine (slave).
// Signals :
//   start        master->slave  one-cycle request to validate and search
//   load_valid   master->slave  write one clue cell
//   load_index   master->slave  clue cell index, row-major r*GRID_LEN+c
//   load_value   master->slave  one-hot digit, zero clears the cell
//   load_ready   slave->master  engine is idle and accepts loads/start
//   rd_index     master->slave  read-back cell index
//   rd_value     slave->master  value stored at rd_index (combinational)
//   busy         slave->master  validating or searching
//   done_success slave->master  sticky, solved grid is held
//   done_failure slave->master  sticky, clue conflict or no solution
//   steps        slave->master  SEARCH+BACK cycles since last start
// -----------------------------------------------------------------------------
interface grid_backtrack_engine_if #(
   parameter int GRID_ORD = 3,
   parameter int IDX_W    = $clog2(GRID_ORD*GRID_ORD*GRID_ORD*GRID_ORD),
   parameter int STEP_W   = 32
);
   localparam int GRID_LEN = GRID_ORD*GRID_ORD;

   logic                start;
   logic                load_valid;
   logic [IDX_W-1:0]    load_index;
   logic [GRID_LEN-1:0] load_value;
   logic                load_ready;
   logic [IDX_W-1:0]    rd_index;
   logic [GRID_LEN-1:0] rd_value;
   logic                busy;
   logic                done_success;
   logic                done_failure;
   logic [STEP_W-1:0]   steps;

   modport master (
      output start, load_valid, load_index, load_value, rd_index,
      input  load_ready, rd_value, busy, done_success, done_failure, steps
   );

   modport slave (
      input  start, load_valid, load_index, load_value, rd_index,
      output load_ready, rd_value, busy, done_success, done_failure, steps
   );
endinterface

// File: rtl/grid_backtrack_engine.sv
// -----------------------------------------------------------------------------
// grid_backtrack_engine
// Purpose : single-walker sudoku solver. A cursor walks all cells; first a
//           validation pass checks the clue cells against each other, then a
//           lowest-first backtracking search fills the remaining cells.
//           Row/column/block occupancy masks live in registers.
// Ports   :
//   clock  rising-edge clock
//   reset  asynchronous active-low reset, clears all state including clues
//   bus    grid_backtrack_engine_if.slave (load/start/read-back/status)
// -----------------------------------------------------------------------------
module grid_backtrack_engine #(
   parameter int GRID_ORD = 3,
   parameter int IDX_W    = $clog2(GRID_ORD*GRID_ORD*GRID_ORD*GRID_ORD),
   parameter int STEP_W   = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   grid_backtrack_engine_if.slave    bus
);

   localparam int GRID_LEN  = GRID_ORD*GRID_ORD;
   localparam int GRID_AREA = GRID_LEN*GRID_LEN;
   localparam int ROW_W     = (GRID_LEN > 1) ? $clog2(GRID_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GRID_AREA-1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_VALIDATE = 2'd1,
      S_SEARCH   = 2'd2,
      S_BACK     = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [GRID_LEN-1:0]  r_value [GRID_AREA];
   logic [GRID_AREA-1:0] r_given;
   logic [GRID_LEN-1:0]  r_rowm  [GRID_LEN];
   logic [GRID_LEN-1:0]  r_colm  [GRID_LEN];
   logic [GRID_LEN-1:0]  r_blkm  [GRID_LEN];
   logic [IDX_W-1:0]     r_cursor;
   logic [STEP_W-1:0]    r_steps;
   logic                 r_done_succ;
   logic                 r_done_fail;

   logic [ROW_W-1:0]     w_row;
   logic [ROW_W-1:0]     w_col;
   logic [ROW_W-1:0]     w_blk;
   logic [GRID_LEN-1:0]  w_cell;
   logic                 w_clue;
   logic [GRID_LEN-1:0]  w_occ;
   logic [GRID_LEN-1:0]  w_cand;
   logic [GRID_LEN-1:0]  w_low;
   logic                 w_conflict;
   logic                 w_first;
   logic                 w_last;
   logic                 w_load_ok;
   logic                 w_start_ok;
   logic [GRID_LEN-1:0]  w_value_ld [GRID_AREA];
   logic [GRID_AREA-1:0] w_given_ld;

   // Digits strictly above a one-hot value; an empty cell allows every digit.
   // For a one-hot v, (v<<1)-1 covers v and everything below it; when v is
   // the top digit the shift wraps to zero and the result is correctly empty.
   function automatic logic [GRID_LEN-1:0] f_above(input logic [GRID_LEN-1:0] v);
      logic [GRID_LEN-1:0] shl;
      if (v == '0) return '1;
      shl = v << 1;
      return ~(shl - GRID_LEN'(1));
   endfunction

   // Isolate the lowest set bit (two's-complement trick).
   function automatic logic [GRID_LEN-1:0] f_lowest(input logic [GRID_LEN-1:0] v);
      return v & (~v + GRID_LEN'(1));
   endfunction

   function automatic logic f_multi_hot(input logic [GRID_LEN-1:0] v);
      return |(v & (v - GRID_LEN'(1)));
   endfunction

   // ---------------------------------------------------------------- cursor decode
   always_comb begin
      w_row      = ROW_W'(r_cursor / IDX_W'(GRID_LEN));
      w_col      = ROW_W'(r_cursor % IDX_W'(GRID_LEN));
      w_blk      = ROW_W'(((w_row / ROW_W'(GRID_ORD)) * ROW_W'(GRID_ORD)) +
                          (w_col / ROW_W'(GRID_ORD)));
      w_cell     = r_value[r_cursor];
      w_clue     = r_given[r_cursor];
      w_occ      = r_rowm[w_row] | r_colm[w_col] | r_blkm[w_blk];
      w_cand     = ~w_occ & f_above(w_cell);
      w_low      = f_lowest(w_cand);
      w_conflict = f_multi_hot(w_cell) | (|(w_cell & w_occ));
      w_first    = (r_cursor == '0);
      w_last     = (r_cursor == LAST_IDX);
      w_load_ok  = bus.load_valid && (r_state == S_IDLE);
      w_start_ok = bus.start && (r_state == S_IDLE);
   end

   // Clue load is applied before start's clearing of non-clue cells, so a
   // same-cycle load and start both take effect.
   always_comb begin
      for (int i = 0; i < GRID_AREA; i++) begin
         w_value_ld[i] = r_value[i];
         w_given_ld[i] = r_given[i];
         if (w_load_ok && (bus.load_index == IDX_W'(i))) begin
            w_value_ld[i] = bus.load_value;
            w_given_ld[i] = |bus.load_value;
         end
         if (w_start_ok && !w_given_ld[i]) begin
            w_value_ld[i] = '0;
         end
      end
   end

   // ---------------------------------------------------------------- FSM: state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // ---------------------------------------------------------------- FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_state_nxt = S_VALIDATE;
         end
         S_VALIDATE: begin
            if (w_clue && w_conflict) w_state_nxt = S_IDLE;
            else if (w_last)          w_state_nxt = S_SEARCH;
         end
         S_SEARCH: begin
            if (w_clue || (w_cand != '0)) begin
               if (w_last) w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = w_first ? S_IDLE : S_BACK;
            end
         end
         S_BACK: begin
            // A clue cannot change, so keep retreating past it.
            if (w_clue) w_state_nxt = w_first ? S_IDLE : S_BACK;
            else        w_state_nxt = S_SEARCH;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FSM: outputs
   always_comb begin
      bus.load_ready   = (r_state == S_IDLE);
      bus.busy         = (r_state != S_IDLE);
      bus.done_success = r_done_succ;
      bus.done_failure = r_done_fail;
      bus.steps        = r_steps;
      bus.rd_value     = '0;
      if (32'(bus.rd_index) < GRID_AREA) bus.rd_value = r_value[bus.rd_index];
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < GRID_AREA; i++) r_value[i] <= '0;
         for (int j = 0; j < GRID_LEN; j++) begin
            r_rowm[j] <= '0;
            r_colm[j] <= '0;
            r_blkm[j] <= '0;
         end
         r_given     <= '0;
         r_cursor    <= '0;
         r_steps     <= '0;
         r_done_succ <= 1'b0;
         r_done_fail <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               for (int i = 0; i < GRID_AREA; i++) r_value[i] <= w_value_ld[i];
               r_given <= w_given_ld;
               if (w_start_ok) begin
                  for (int j = 0; j < GRID_LEN; j++) begin
                     r_rowm[j] <= '0;
                     r_colm[j] <= '0;
                     r_blkm[j] <= '0;
                  end
                  r_cursor    <= '0;
                  r_steps     <= '0;
                  r_done_succ <= 1'b0;
                  r_done_fail <= 1'b0;
               end
            end

            S_VALIDATE: begin
               if (w_clue) begin
                  if (w_conflict) begin
                     r_done_fail <= 1'b1;
                  end else begin
                     r_rowm[w_row] <= r_rowm[w_row] | w_cell;
                     r_colm[w_col] <= r_colm[w_col] | w_cell;
                     r_blkm[w_blk] <= r_blkm[w_blk] | w_cell;
                  end
               end
               r_cursor <= w_last ? '0 : r_cursor + IDX_W'(1);
            end

            S_SEARCH: begin
               if (r_steps != '1) r_steps <= r_steps + STEP_W'(1);
               if (w_clue || (w_cand != '0)) begin
                  if (!w_clue) begin
                     r_value[r_cursor] <= w_low;
                     r_rowm[w_row]     <= (r_rowm[w_row] & ~w_cell) | w_low;
                     r_colm[w_col]     <= (r_colm[w_col] & ~w_cell) | w_low;
                     r_blkm[w_blk]     <= (r_blkm[w_blk] & ~w_cell) | w_low;
                  end
                  if (w_last) r_done_succ <= 1'b1;
                  else        r_cursor    <= r_cursor + IDX_W'(1);
               end else begin
                  r_value[r_cursor] <= '0;
                  r_rowm[w_row]     <= r_rowm[w_row] & ~w_cell;
                  r_colm[w_col]     <= r_colm[w_col] & ~w_cell;
                  r_blkm[w_blk]     <= r_blkm[w_blk] & ~w_cell;
                  if (w_first) r_done_fail <= 1'b1;
                  else         r_cursor    <= r_cursor - IDX_W'(1);
               end
            end

            S_BACK: begin
               if (r_steps != '1) r_steps <= r_steps + STEP_W'(1);
               if (w_clue) begin
                  if (w_first) r_done_fail <= 1'b1;
                  else         r_cursor    <= r_cursor - IDX_W'(1);
               end
            end

            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grid_backtrack_engine.sv
`timescale 1ns/1ps
module tb_grid_backtrack_engine;

   localparam int GRID_ORD = 2;
   localparam int IDX_W    = 4;
   localparam int STEP_W   = 32;

   // Expected solution of the empty 4x4 grid: 1234 / 3412 / 2143 / 4321,
   // one decimal digit per nibble, cell 0 in the top nibble.
   localparam logic [63:0] SOL = 64'h1234_3412_2143_4321;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   grid_backtrack_engine_if #(.GRID_ORD(GRID_ORD), .IDX_W(IDX_W), .STEP_W(STEP_W)) bus ();

   grid_backtrack_engine #(.GRID_ORD(GRID_ORD), .IDX_W(IDX_W), .STEP_W(STEP_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [7:0]  id;
      logic        succ;
      logic        fail;
      logic [31:0] steps;
      logic [31:0] lat;
      logic [63:0] vals;
   } exp_t;

   exp_t sb_q[$];
   int   errors    = 0;
   int   checks    = 0;
   int   cyc       = 0;
   int   start_cyc = 0;
   logic mon_prev  = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] oh(input logic [3:0] d);
      return (d == 4'd0) ? 4'b0000 : (4'b0001 << (d - 4'd1));
   endfunction

   function automatic logic [63:0] grid_oh(input logic [63:0] digits);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[63-4*i -: 4] = oh(digits[63-4*i -: 4]);
      return r;
   endfunction

   function automatic exp_t mk(input int id, input logic s, input logic f,
                               input int st, input int lat, input logic [63:0] digits);
      exp_t e;
      e.id    = 8'(id);
      e.succ  = s;
      e.fail  = f;
      e.steps = 32'(st);
      e.lat   = 32'(lat);
      e.vals  = grid_oh(digits);
      return e;
   endfunction

   task automatic load_cell(input int idx, input logic [3:0] v);
      @(negedge clock);
      bus.load_valid = 1'b1;
      bus.load_index = IDX_W'(idx);
      bus.load_value = v;
      @(negedge clock);
      bus.load_valid = 1'b0;
   endtask

   task automatic load_grid(input logic [63:0] digits);
      for (int i = 0; i < 16; i++) load_cell(i, oh(digits[63-4*i -: 4]));
   endtask

   task automatic pulse_start(input exp_t e);
      @(negedge clock);
      bus.start = 1'b1;
      start_cyc = cyc + 1;
      sb_q.push_back(e);
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!(bus.done_success || bus.done_failure) && n < 300) begin
         @(negedge clock);
         n++;
      end
      check({name, "_timeout"}, (n >= 300), 0);
      repeat (3) @(negedge clock);
   endtask

   // Monitor: on each rising completion flag, pop the expected record and
   // compare flags, step count, latency from the start edge and the grid.
   initial begin
      exp_t e;
      logic now;
      forever begin
         @(negedge clock);
         now = bus.done_success | bus.done_failure;
         if (now && !mon_prev) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_done", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("s%0d_done_success", e.id), bus.done_success, e.succ);
               check($sformatf("s%0d_done_failure", e.id), bus.done_failure, e.fail);
               check($sformatf("s%0d_steps", e.id), bus.steps, e.steps);
               check($sformatf("s%0d_latency", e.id), 32'(cyc - start_cyc), e.lat);
               for (int i = 0; i < 16; i++) begin
                  bus.rd_index = IDX_W'(i);
                  #0.1;
                  check($sformatf("s%0d_cell%0d", e.id, i), bus.rd_value, e.vals[63-4*i -: 4]);
               end
            end
         end
         mon_prev = now;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      int bad;
      bus.start      = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_index = '0;
      bus.load_value = '0;
      bus.rd_index   = '0;

      // Reset state
      #12;
      check("rst_busy", bus.busy, 0);
      check("rst_done_success", bus.done_success, 0);
      check("rst_done_failure", bus.done_failure, 0);
      check("rst_steps", bus.steps, 0);
      check("rst_load_ready", bus.load_ready, 1);
      check("rst_rd_value", bus.rd_value, 0);
      @(negedge clock);
      reset = 1'b1;

      // 1: empty grid solves greedily with no backtracking
      pulse_start(mk(1, 1'b1, 1'b0, 16, 32, SOL));
      wait_done("s1");

      // 2: full valid grid as clues, nothing changes
      load_grid(SOL);
      pulse_start(mk(2, 1'b1, 1'b0, 16, 32, SOL));
      wait_done("s2");

      // 3: duplicate digit in row 0 fails in validation at cell 1
      load_grid(64'h1100_0000_0000_0000);
      pulse_start(mk(3, 1'b0, 1'b1, 0, 2, 64'h1100_0000_0000_0000));
      wait_done("s3");

      // 4: consistent clues, unsolvable: cells 0 and 1 both need digit 4.
      // Trace: S0 writes 4, S1 has no candidate, B0, S0 exhausted -> 4 steps,
      // done 16+4 edges after start; search cells end cleared.
      load_grid(64'h0010_2300_0000_0000);
      pulse_start(mk(4, 1'b0, 1'b1, 4, 20, 64'h0010_2300_0000_0000));
      wait_done("s4");

      // 5: reset in the middle of a run clears everything including clues
      @(negedge clock);
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (19) @(negedge clock);
      check("s5_busy_before_reset", bus.busy, 1);
      bus.rd_index = IDX_W'(5);
      #1;
      reset = 1'b0;
      #1;
      check("s5_busy", bus.busy, 0);
      check("s5_done_success", bus.done_success, 0);
      check("s5_done_failure", bus.done_failure, 0);
      check("s5_steps", bus.steps, 0);
      check("s5_load_ready", bus.load_ready, 1);
      check("s5_rd_value_cell5", bus.rd_value, 0);
      @(negedge clock);
      reset = 1'b1;
      pulse_start(mk(5, 1'b1, 1'b0, 16, 32, SOL));
      wait_done("s5");

      // 6: start/load while busy are ignored; load_ready low throughout
      pulse_start(mk(6, 1'b1, 1'b0, 16, 32, SOL));
      n   = 0;
      bad = 0;
      while (!(bus.done_success || bus.done_failure) && n < 300) begin
         @(negedge clock);
         if (n == 5 || n == 20) begin
            bus.start      = 1'b1;
            bus.load_valid = 1'b1;
            bus.load_index = IDX_W'(3);
            bus.load_value = 4'b1000;
         end else begin
            bus.start      = 1'b0;
            bus.load_valid = 1'b0;
         end
         if (bus.busy && bus.load_ready) bad++;
         n++;
      end
      bus.start      = 1'b0;
      bus.load_valid = 1'b0;
      check("s6_timeout", (n >= 300), 0);
      check("s6_load_ready_while_busy", bad, 0);
      repeat (3) @(negedge clock);

      check("sb_drain", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
